// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Single-clock parametrised FIFO with fill count, almost flags,
//               sticky overflow/underflow and selectable FWFT read mode.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 3,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int             c_DEPTH  = 1 << ASIZE;
    localparam logic [ASIZE:0] c_AFULL  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] c_AEMPTY = (ASIZE+1)'(AEMPTY_TH);

    logic [DSIZE-1:0] r_mem [c_DEPTH];

    logic [ASIZE:0]   r_wptr_q, w_wptr_d;
    logic [ASIZE:0]   r_rptr_q, w_rptr_d;
    logic             r_overflow_q, w_overflow_d;
    logic             r_underflow_q, w_underflow_d;

    logic [ASIZE-1:0] w_waddr, w_raddr;
    logic             w_full, w_empty, w_wr_ok, w_rd_ok;

    // All status is derived from the registered pointers only
    assign w_waddr = r_wptr_q[ASIZE-1:0];
    assign w_raddr = r_rptr_q[ASIZE-1:0];
    assign w_empty = (r_wptr_q == r_rptr_q);
    assign w_full  = (r_wptr_q[ASIZE] != r_rptr_q[ASIZE]) && (w_waddr == w_raddr);
    assign w_wr_ok = winc & ~w_full;
    assign w_rd_ok = rinc & ~w_empty;

    always_comb begin
        w_wptr_d      = r_wptr_q;
        w_rptr_d      = r_rptr_q;
        w_overflow_d  = r_overflow_q | (winc & w_full);
        w_underflow_d = r_underflow_q | (rinc & w_empty);
        if (w_wr_ok) w_wptr_d = r_wptr_q + 1'b1;
        if (w_rd_ok) w_rptr_d = r_rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr_q      <= '0;
            r_rptr_q      <= '0;
            r_overflow_q  <= 1'b0;
            r_underflow_q <= 1'b0;
        end else begin
            r_wptr_q      <= w_wptr_d;
            r_rptr_q      <= w_rptr_d;
            r_overflow_q  <= w_overflow_d;
            r_underflow_q <= w_underflow_d;
        end
    end

    // Storage is deliberately left uninitialised on reset
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) r_mem[w_waddr] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = w_empty ? '0 : r_mem[w_raddr];
        end else begin : g_std
            logic [DSIZE-1:0] r_rdata_q, w_rdata_d;

            always_comb begin
                w_rdata_d = r_rdata_q;
                if (w_rd_ok) w_rdata_d = r_mem[w_raddr];
            end

            always_ff @(posedge clk) begin
                if (rst) r_rdata_q <= '0;
                else     r_rdata_q <= w_rdata_d;
            end

            assign rdata = r_rdata_q;
        end
    endgenerate

    assign count         = r_wptr_q - r_rptr_q;
    assign rempty        = w_empty;
    assign wfull         = w_full;
    assign walmost_full  = (count >= c_AFULL);
    assign ralmost_empty = (count <= c_AEMPTY);
    assign overflow      = r_overflow_q;
    assign underflow     = r_underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Bench for sync_fifo_param, standard and FWFT instances side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst, winc, rinc;
    logic [7:0] wdata;

    logic [7:0] rdata_s, rdata_f;
    logic [3:0] count_s, count_f;
    logic       wfull_s, rempty_s, waf_s, rae_s, ovf_s, unf_s;
    logic       wfull_f, rempty_f, waf_f, rae_f, ovf_f, unf_f;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain queue plus sticky bits
    logic [7:0] q[$];
    logic       m_ovf, m_unf;
    logic [7:0] m_rdata;

    always #5 clk = ~clk;

    sync_fifo_param #(.DSIZE(8), .ASIZE(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc),
        .rdata(rdata_s), .wfull(wfull_s), .rempty(rempty_s), .walmost_full(waf_s),
        .ralmost_empty(rae_s), .count(count_s), .overflow(ovf_s), .underflow(unf_s)
    );

    sync_fifo_param #(.DSIZE(8), .ASIZE(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc),
        .rdata(rdata_f), .wfull(wfull_f), .rempty(rempty_f), .walmost_full(waf_f),
        .ralmost_empty(rae_f), .count(count_f), .overflow(ovf_f), .underflow(unf_f)
    );

    function automatic void model_step();
        bit full, empty;
        if (rst) begin
            q.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_rdata = 8'h00;
            return;
        end
        full  = (q.size() == 8);
        empty = (q.size() == 0);
        if (winc && full)   m_ovf = 1'b1;
        if (rinc && empty)  m_unf = 1'b1;
        if (rinc && !empty) m_rdata = q.pop_front();
        if (winc && !full)  q.push_back(wdata);
    endfunction

    task automatic cycle(input logic r, input logic w, input logic [7:0] d, input logic rd);
        rst = r; winc = w; wdata = d; rinc = rd;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'bx, 8'hxx, 1'bx);
        cycle(1'b1, 1'bx, 8'hxx, 1'bx);
        checks++;
        if ({rempty_s, wfull_s, count_s, rae_s, waf_s, ovf_s, unf_s} !== {1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=%b", {rempty_s, wfull_s, count_s, rae_s, waf_s, ovf_s, unf_s}, 10'b1000001000);
        end
        checks++;
        if (rdata_s !== 8'h00 || rdata_f !== 8'h00) begin
            failures++;
            $display("FAIL reset_rdata got std=%h fwft=%h exp=00", rdata_s, rdata_f);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
            checks++;
            if ({count_s, waf_s, wfull_s, rae_s} !== {4'(i + 1), (i + 1 >= 6), (i == 7), (i + 1 <= 1)}) begin
                failures++;
                $display("FAIL fill_status i=%0d got cnt=%0d af=%b full=%b ae=%b exp cnt=%0d af=%b full=%b ae=%b",
                         i, count_s, waf_s, wfull_s, rae_s, i + 1, (i + 1 >= 6), (i == 7), (i + 1 <= 1));
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rdata_f !== 8'hA0 + 8'(i)) begin
                failures++;
                $display("FAIL drain_fwft_head i=%0d got=%h exp=%h", i, rdata_f, 8'hA0 + 8'(i));
            end
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            checks++;
            if (rdata_s !== 8'hA0 + 8'(i) || count_s !== 4'(7 - i)) begin
                failures++;
                $display("FAIL drain_std i=%0d got data=%h cnt=%0d exp data=%h cnt=%0d",
                         i, rdata_s, count_s, 8'hA0 + 8'(i), 7 - i);
            end
        end
        checks++;
        if (rempty_s !== 1'b1 || rempty_f !== 1'b1) begin
            failures++;
            $display("FAIL drain_empty got std=%b fwft=%b exp=1", rempty_s, rempty_f);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
        cycle(1'b0, 1'b1, 8'hFF, 1'b0);
        checks++;
        if ({ovf_s, wfull_s, count_s} !== {1'b1, 1'b1, 4'd8}) begin
            failures++;
            $display("FAIL overflow_set got ovf=%b full=%b cnt=%0d exp ovf=1 full=1 cnt=8", ovf_s, wfull_s, count_s);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            checks++;
            if (rdata_s !== 8'hA0 + 8'(i) || ovf_s !== 1'b1) begin
                failures++;
                $display("FAIL overflow_drain i=%0d got data=%h ovf=%b exp data=%h ovf=1", i, rdata_s, ovf_s, 8'hA0 + 8'(i));
            end
        end
        checks++;
        if (rempty_s !== 1'b1) begin
            failures++;
            $display("FAIL overflow_rejected_word got rempty=%b exp=1", rempty_s);
        end
    endtask

    task automatic test_underflow();
        cycle(1'b0, 1'b1, 8'h55, 1'b1);
        checks++;
        if ({unf_s, count_s, rempty_s} !== {1'b1, 4'd1, 1'b0} || rdata_f !== 8'h55) begin
            failures++;
            $display("FAIL underflow_simul got unf=%b cnt=%0d empty=%b fw=%h exp unf=1 cnt=1 empty=0 fw=55",
                     unf_s, count_s, rempty_s, rdata_f);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (rdata_s !== 8'h55 || rempty_s !== 1'b1 || unf_s !== 1'b1) begin
            failures++;
            $display("FAIL underflow_read got data=%h empty=%b unf=%b exp data=55 empty=1 unf=1", rdata_s, rempty_s, unf_s);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h10 + 8'(i), 1'b0);
        for (int n = 0; n < 20; n++) begin
            cycle(1'b0, 1'b1, 8'h14 + 8'(n), 1'b1);
            checks++;
            if (count_s !== 4'd4 || rdata_s !== 8'h10 + 8'(n)) begin
                failures++;
                $display("FAIL b2b n=%0d got cnt=%0d data=%h exp cnt=4 data=%h", n, count_s, rdata_s, 8'h10 + 8'(n));
            end
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (rdata_s !== 8'h27 || rempty_s !== 1'b1) begin
            failures++;
            $display("FAIL b2b_tail got data=%h empty=%b exp data=27 empty=1", rdata_s, rempty_s);
        end
    endtask

    task automatic test_fwft();
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (rdata_f !== 8'h00 || rempty_f !== 1'b1) begin
            failures++;
            $display("FAIL fwft_idle got data=%h empty=%b exp data=00 empty=1", rdata_f, rempty_f);
        end
        cycle(1'b0, 1'b1, 8'h3C, 1'b0);
        checks++;
        if (rdata_f !== 8'h3C || rempty_f !== 1'b0) begin
            failures++;
            $display("FAIL fwft_show got data=%h empty=%b exp data=3c empty=0", rdata_f, rempty_f);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (rdata_f !== 8'h00 || rempty_f !== 1'b1) begin
            failures++;
            $display("FAIL fwft_pop got data=%h empty=%b exp data=00 empty=1", rdata_f, rempty_f);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rdata_f !== 8'hA0 + 8'(i)) begin
                failures++;
                $display("FAIL fwft_drain i=%0d got=%h exp=%h", i, rdata_f, 8'hA0 + 8'(i));
            end
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_random();
        logic [11:0] exp_st;
        logic [7:0]  exp_fw;
        int          pw;
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int n = 0; n < 600; n++) begin
            pw = ((n / 60) % 2 == 0) ? 75 : 25;
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < pw),
                  8'($urandom), ($urandom_range(0, 99) >= pw));
            exp_st = {4'(q.size()), (q.size() == 0), (q.size() == 8), (q.size() >= 6),
                      (q.size() <= 1), m_ovf, m_unf, 2'b00};
            exp_fw = (q.size() != 0) ? q[0] : 8'h00;
            checks++;
            if ({count_s, rempty_s, wfull_s, waf_s, rae_s, ovf_s, unf_s, 2'b00} !== exp_st ||
                {count_f, rempty_f, wfull_f, waf_f, rae_f, ovf_f, unf_f, 2'b00} !== exp_st) begin
                failures++;
                $display("FAIL rand_status n=%0d got std=%b fwft=%b exp=%b", n,
                         {count_s, rempty_s, wfull_s, waf_s, rae_s, ovf_s, unf_s, 2'b00},
                         {count_f, rempty_f, wfull_f, waf_f, rae_f, ovf_f, unf_f, 2'b00}, exp_st);
            end
            checks++;
            if (rdata_s !== m_rdata || rdata_f !== exp_fw) begin
                failures++;
                $display("FAIL rand_rdata n=%0d got std=%h fwft=%h exp std=%h fwft=%h", n, rdata_s, rdata_f, m_rdata, exp_fw);
            end
        end
    endtask

    initial begin
        rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_fwft();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
